// File: rtl/crypto_rsa_modexp_pkg.sv
// Shared types and constants for the RSA modular-exponentiation engine.
package crypto_rsa_modexp_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SQR,
        ST_MUL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/crypto_rsa_modexp_if.sv
// Key load and start/ready/done job bus of the RSA modexp engine.
interface crypto_rsa_modexp_if import crypto_rsa_modexp_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] key_e;
    logic [WIDTH-1:0] key_d;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic             error;

    modport master (
        output load, n, key_e, key_d, start, mode, data_in,
        input  ready, done, data_out, error
    );

    modport slave (
        input  load, n, key_e, key_d, start, mode, data_in,
        output ready, done, data_out, error
    );

endinterface

// File: rtl/crypto_rsa_modmul.sv
// Bit-serial MSB-first interleaved modular multiplier: p = a*b mod n.
module crypto_rsa_modmul import crypto_rsa_modexp_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [CW-1:0]    cnt;
    logic             busy;

    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_r;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt;

    // acc and b stay below n, so one conditional subtract per step suffices
    always_comb begin
        n_ext = {1'b0, n_r};
        dbl   = {acc, 1'b0};
        dbl_r = (dbl >= n_ext) ? dbl - n_ext : dbl;
        sum   = a_sh[WIDTH-1] ? dbl_r + {1'b0, b_r} : dbl_r;
        nxt   = (sum >= n_ext) ? WIDTH'(sum - n_ext) : WIDTH'(sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            a_sh <= '0;
            b_r  <= '0;
            n_r  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            p    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc  <= '0;
                a_sh <= a;
                b_r  <= b;
                n_r  <= n;
                cnt  <= CW'(WIDTH);
                busy <= 1'b1;
            end else if (busy) begin
                acc  <= nxt;
                a_sh <= a_sh << 1;
                cnt  <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    p    <= nxt;
                end
            end
        end
    end

endmodule

// File: rtl/crypto_rsa_modexp.sv
// Constant-time left-to-right square-and-multiply RSA engine with key store.
module crypto_rsa_modexp import crypto_rsa_modexp_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                reset,
    crypto_rsa_modexp_if.slave bus
);

    localparam int IW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] ke;
    logic [WIDTH-1:0] kd;
    logic             keys_valid;
    logic             mode_r;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] ex;
    logic [IW-1:0]    i;
    logic             issued;
    logic             ready_r;
    logic             done_r;
    logic             error_r;
    logic [WIDTH-1:0] out_r;

    logic             bad;
    logic             mm_start;
    logic             mm_done;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_p;

    assign bad = !keys_valid || (n_r < WIDTH'(2))
               || (bus.data_in >= n_r);
    assign mm_start = (state == ST_SQR || state == ST_MUL) && !issued;
    assign mm_b     = (state == ST_SQR) ? r : base;

    assign bus.ready    = ready_r;
    assign bus.done     = done_r;
    assign bus.error    = error_r;
    assign bus.data_out = out_r;

    crypto_rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (r),
        .b     (mm_b),
        .n     (n_r),
        .done  (mm_done),
        .p     (mm_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            n_r        <= '0;
            ke         <= '0;
            kd         <= '0;
            keys_valid <= 1'b0;
            mode_r     <= MODE_ENC;
            base       <= '0;
            r          <= '0;
            ex         <= '0;
            i          <= '0;
            issued     <= 1'b0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            out_r      <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.load) begin
                        n_r        <= bus.n;
                        ke         <= bus.key_e;
                        kd         <= bus.key_d;
                        keys_valid <= 1'b1;
                    end else if (bus.start) begin
                        ready_r <= 1'b0;
                        if (bad) begin
                            state   <= ST_DONE;
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                            out_r   <= '0;
                        end else begin
                            state  <= ST_INIT;
                            mode_r <= bus.mode;
                            base   <= bus.data_in;
                        end
                    end
                end
                ST_INIT: begin
                    r      <= WIDTH'(1);
                    ex     <= (mode_r == MODE_DEC) ? kd : ke;
                    i      <= IW'(WIDTH - 1);
                    issued <= 1'b0;
                    state  <= ST_SQR;
                end
                ST_SQR: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        r      <= mm_p;
                        issued <= 1'b0;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        // product is always formed; only the commit depends on the key bit
                        issued <= 1'b0;
                        ex     <= ex << 1;
                        if (ex[WIDTH-1]) r <= mm_p;
                        if (i == '0) begin
                            state   <= ST_DONE;
                            done_r  <= 1'b1;
                            error_r <= 1'b0;
                            out_r   <= ex[WIDTH-1] ? mm_p : r;
                        end else begin
                            i     <= i - IW'(1);
                            state <= ST_SQR;
                        end
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_rsa_modexp.sv
// Scoreboard bench: directed 32-bit jobs plus random 16-bit pow-mod jobs.
`timescale 1ns/1ps
module tb_crypto_rsa_modexp;
    import crypto_rsa_modexp_pkg::*;

    localparam int W32   = 32;
    localparam int W16   = 16;
    localparam int LAT32 = 2 * W32 * (W32 + 2) + 2;
    localparam int LAT16 = 2 * W16 * (W16 + 2) + 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    crypto_rsa_modexp_if #(.WIDTH(W32)) bus32();
    crypto_rsa_modexp_if #(.WIDTH(W16)) bus16();

    crypto_rsa_modexp #(.WIDTH(W32)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32.slave)
    );
    crypto_rsa_modexp #(.WIDTH(W16)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] powmod(input logic [31:0] b,
                                           input logic [31:0] e,
                                           input logic [31:0] m);
        logic [63:0] mm, acc, x;
        mm  = {32'd0, m};
        acc = 64'd1 % mm;
        x   = {32'd0, b} % mm;
        for (int k = 0; k < 32; k++) begin
            if (e[k]) acc = (acc * x) % mm;
            x = (x * x) % mm;
        end
        return acc[31:0];
    endfunction

    task automatic load32(input logic [31:0] nn, input logic [31:0] ee,
                          input logic [31:0] dd);
        @(negedge clk);
        bus32.load = 1'b1; bus32.n = nn; bus32.key_e = ee; bus32.key_d = dd;
        @(negedge clk);
        bus32.load = 1'b0;
    endtask

    // One 32-bit job; pulse_at>0 fires start+load with foreign values mid-job.
    task automatic job32(input logic m, input logic [31:0] din,
                         input logic [31:0] want, input logic want_err,
                         input string tag, input int pulse_at);
        exp_t e;
        int   cyc;
        bit   rdy_bad;
        e.data = want; e.err = want_err;
        e.lat  = want_err ? 1 : LAT32;
        sb.push_back(e);
        @(negedge clk);
        bus32.start = 1'b1; bus32.mode = m; bus32.data_in = din;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        cyc = 1; rdy_bad = 0;
        while (!bus32.done && cyc < LAT32 + 20) begin
            if (bus32.ready) rdy_bad = 1;
            if (pulse_at > 0 && cyc == pulse_at) begin
                bus32.start = 1'b1; bus32.load = 1'b1; bus32.n = 32'd77;
                bus32.key_e = 32'd3; bus32.data_in = 32'd5;
            end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
                bus32.start = 1'b0; bus32.load = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (!bus32.done) begin
            failures++;
            $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
            return;
        end
        checks++;
        if (bus32.data_out !== e.data) begin
            failures++;
            $display("FAIL %s data_out: got %0d want %0d", tag, bus32.data_out, e.data);
        end
        checks++;
        if (bus32.error !== e.err) begin
            failures++;
            $display("FAIL %s error: got %0b want %0b", tag, bus32.error, e.err);
        end
        checks++;
        if (cyc != e.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", tag, cyc, e.lat);
        end
        checks++;
        if (rdy_bad || bus32.ready !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_busy: ready seen high during job", tag);
        end
        @(posedge clk); #1;
        checks++;
        if (bus32.ready !== 1'b1 || bus32.done !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: ready=%0b done=%0b want 1/0",
                     tag, bus32.ready, bus32.done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus32.load = 0; bus32.start = 0; bus32.mode = 0; bus32.n = 0;
        bus32.key_e = 0; bus32.key_d = 0; bus32.data_in = 0;
        bus16.load = 0; bus16.start = 0; bus16.mode = 0; bus16.n = 0;
        bus16.key_e = 0; bus16.key_d = 0; bus16.data_in = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus32.ready !== 1'b1 || bus32.done !== 1'b0 || bus32.error !== 1'b0
            || bus32.data_out !== 32'd0) begin
            failures++;
            $display("FAIL reset32: ready=%0b done=%0b error=%0b data_out=%0d want 1/0/0/0",
                     bus32.ready, bus32.done, bus32.error, bus32.data_out);
        end
        checks++;
        if (bus16.ready !== 1'b1 || bus16.done !== 1'b0) begin
            failures++;
            $display("FAIL reset16: ready=%0b done=%0b want 1/0", bus16.ready, bus16.done);
        end
    endtask

    task automatic test_no_keys;
        job32(MODE_ENC, 32'd9, 32'd0, 1'b1, "no_keys", 0);
    endtask

    task automatic test_encrypt;
        load32(32'd143, 32'd7, 32'd103);
        job32(MODE_ENC, 32'd9, 32'd48, 1'b0, "encrypt", 0);
    endtask

    task automatic test_decrypt;
        job32(MODE_DEC, 32'd48, 32'd9, 1'b0, "decrypt", 0);
    endtask

    task automatic test_bad_input;
        job32(MODE_ENC, 32'd143, 32'd0, 1'b1, "din_eq_n", 0);
        job32(MODE_DEC, 32'd200, 32'd0, 1'b1, "din_gt_n", 0);
    endtask

    task automatic test_mid_job_ignore;
        job32(MODE_ENC, 32'd9, 32'd48, 1'b0, "mid_job_pulse", 500);
        job32(MODE_DEC, 32'd48, 32'd9, 1'b0, "keys_kept", 0);
    endtask

    task automatic test_edge_values;
        load32(32'd143, 32'd0, 32'd103);
        job32(MODE_ENC, 32'd5, 32'd1, 1'b0, "exp_zero", 0);
        job32(MODE_DEC, 32'd0, 32'd0, 1'b0, "din_zero", 0);
        job32(MODE_DEC, 32'd1, 32'd1, 1'b0, "din_one", 0);
    endtask

    task automatic test_load_start_same;
        bit bad_seen;
        @(negedge clk);
        bus32.load = 1'b1; bus32.start = 1'b1; bus32.mode = MODE_ENC;
        bus32.n = 32'd143; bus32.key_e = 32'd7; bus32.key_d = 32'd103;
        bus32.data_in = 32'd9;
        @(negedge clk);
        bus32.load = 1'b0; bus32.start = 1'b0;
        bad_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus32.ready !== 1'b1 || bus32.done !== 1'b0) bad_seen = 1;
        end
        checks++;
        if (bad_seen) begin
            failures++;
            $display("FAIL load_start_same: job started (ready=%0b done=%0b) want idle",
                     bus32.ready, bus32.done);
        end
        job32(MODE_ENC, 32'd9, 32'd48, 1'b0, "keys_updated", 0);
    endtask

    task automatic test_reset_mid_job;
        bit pulsed;
        @(negedge clk);
        bus32.start = 1'b1; bus32.mode = MODE_ENC; bus32.data_in = 32'd9;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (999) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus32.ready !== 1'b1 || bus32.done !== 1'b0 || bus32.data_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_job: ready=%0b done=%0b data_out=%0d want 1/0/0",
                     bus32.ready, bus32.done, bus32.data_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulsed = 0;
        for (int k = 0; k < LAT32 + 50; k++) begin
            @(posedge clk); #1;
            if (bus32.done) pulsed = 1;
        end
        checks++;
        if (pulsed) begin
            failures++;
            $display("FAIL aborted_done: done=1 seen want 0");
        end
        job32(MODE_ENC, 32'd9, 32'd0, 1'b1, "after_reset_no_keys", 0);
    endtask

    task automatic test_random16;
        logic [15:0] nn, ee, dd, din, key;
        logic        m;
        exp_t        e;
        int          cyc;
        for (int j = 0; j < 8; j++) begin
            nn  = 16'($urandom_range(3, 65535)) | 16'd1;
            ee  = 16'($urandom);
            dd  = 16'($urandom);
            din = 16'($urandom_range(0, int'(nn) - 1));
            m   = 1'($urandom_range(0, 1));
            key = m ? dd : ee;
            @(negedge clk);
            bus16.load = 1'b1; bus16.n = nn; bus16.key_e = ee; bus16.key_d = dd;
            @(negedge clk);
            bus16.load = 1'b0;
            e.data = powmod({16'd0, din}, {16'd0, key}, {16'd0, nn});
            e.err  = 1'b0;
            e.lat  = LAT16;
            sb.push_back(e);
            bus16.start = 1'b1; bus16.mode = m; bus16.data_in = din;
            @(posedge clk); #1;
            bus16.start = 1'b0;
            cyc = 1;
            while (!bus16.done && cyc < LAT16 + 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            e = sb.pop_front();
            checks++;
            if (!bus16.done || {16'd0, bus16.data_out} !== e.data || bus16.error !== 1'b0
                || cyc != e.lat) begin
                failures++;
                $display("FAIL rand16[%0d] n=%0d k=%0d d=%0d: got %0d err=%0b lat=%0d want %0d err=0 lat=%0d",
                         j, nn, key, din, bus16.data_out, bus16.error, cyc, e.data, e.lat);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_no_keys();
        test_encrypt();
        test_decrypt();
        test_bad_input();
        test_mid_job_ignore();
        test_edge_values();
        test_load_start_same();
        test_reset_mid_job();
        test_random16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
